// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the sysid probe master: FSM state encoding,
// default expected ID/timestamp words and the sysid slave word addresses.
package sysid_probe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    FINISH,
    ERR
  } state_t;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1489014401;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_probe_timer.sv
// Stall counter for one Avalon read: counts waitrequest cycles and flags the
// cycle on which the running total reaches the configured limit.
module sysid_probe_timer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Asserted during the limit-th stalled cycle so the master can drop its
  // read strobe on the very next cycle.
  assign expired = enable && !clear && (count >= (limit - 16'd1));

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares
// them with the expected values. Optional feature: SYSID_PROBE_AUTOSTART_EN.
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  state_t state;
  logic   start_eff;
  logic   reading;
  logic   stall_clear;
  logic   stall_en;
  logic   stall_expired;

`ifdef SYSID_PROBE_AUTOSTART_EN
  // One-shot request that fires in the first cycle after reset release.
  logic auto_pend;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pend <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
    end
  end

  assign start_eff = start || auto_pend;
`else
  assign start_eff = start;
`endif

  assign reading     = (state == RD_ID) || (state == RD_TS);
  assign stall_clear = !reading || !avm_waitrequest;
  assign stall_en    = reading && avm_waitrequest;

  sysid_probe_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (stall_clear),
    .enable  (stall_en),
    .limit   (LIMIT),
    .expired (stall_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FINISH, ERR: begin
          if (start_eff) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            busy        <= 1'b1;
            match       <= 1'b0;
            timeout_err <= 1'b0;
          end else if (state == FINISH) begin
            state <= IDLE;
          end
        end
        RD_ID: begin
          if (!avm_waitrequest) begin
            id_value    <= avm_readdata;
            avm_address <= ADDR_TS;
            state       <= RD_TS;
          end else if (stall_expired) begin
            state       <= ERR;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b1;
            match       <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        RD_TS: begin
          // The ID word is already registered; the timestamp is compared as it arrives.
          if (!avm_waitrequest) begin
            ts_value    <= avm_readdata;
            state       <= FINISH;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b1;
            match       <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TS);
          end else if (stall_expired) begin
            state       <= ERR;
            avm_read    <= 1'b0;
            avm_address <= ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b1;
            match       <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
